ahbl_apb_bridge: RTL and testbench



---
 rtl/ahbl_apb_bridge.sv | 158 +++++++++++++++
 tb/tb_ahbl_apb_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_apb_bridge.sv
// ahbl_apb_bridge: single-outstanding AHB-Lite slave to APB3 master bridge with one-hot slot decode.
// Optional macro APB_TIMEOUT_EN bounds each ACCESS phase to TIMEOUT_CYCLES cycles.
module ahbl_apb_bridge #(
  parameter int unsigned APB_AW   = 12,
  parameter int unsigned NSLOTS   = 16,
  parameter int unsigned SLOT_LSB = 12
`ifdef APB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [APB_AW-1:0] PADDR,
  output logic [NSLOTS-1:0] PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_e;

  state_e              state_q, state_d;
  logic [APB_AW-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [3:0]          slot_q, slot_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [31:0]         hrdata_q, hrdata_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

  logic accept;
  logic dec_err;
  logic apb_phase;

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign dec_err   = (32'(slot_q) >= NSLOTS);
  assign apb_phase = (state_q == S_SETUP) || (state_q == S_ACCESS);

  // HSIZE is accepted but the path is word-only; HTRANS[0] (SEQ vs NONSEQ) does not matter here.
  logic unused_ok;
  assign unused_ok = ^{HSIZE, HTRANS[0], HADDR};

  // NOTE: every variable gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    slot_d   = slot_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
`ifdef APB_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      S_IDLE, S_ERR2: begin
        if (accept) begin
          addr_d  = HADDR[APB_AW-1:0];
          write_d = HWRITE;
          slot_d  = HADDR[SLOT_LSB+3:SLOT_LSB];
          state_d = S_LATCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        if (write_q) pwdata_d = HWDATA;
        state_d = dec_err ? S_ERR1 : S_SETUP;
      end
      S_SETUP: begin
`ifdef APB_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            state_d = S_ERR1;
          end else begin
            if (!write_q) hrdata_d = PRDATA;
            state_d = S_IDLE;
          end
        end
`ifdef APB_TIMEOUT_EN
        // The cycle that would make the count reach the limit is the last ACCESS cycle allowed.
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERR1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      slot_q   <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      slot_q   <= slot_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
`ifdef APB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (apb_phase && (slot_q == 4'(i))) PSEL[i] = 1'b1;
    end
  end

  // Outputs decode straight from the state register, so HRESET clears them without waiting for an edge.
  assign HREADYOUT = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign PENABLE   = (state_q == S_ACCESS);
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = pwdata_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Directed scoreboard bench for ahbl_apb_bridge (NSLOTS=8); define APB_TIMEOUT_EN to add the timeout step.
module tb_ahbl_apb_bridge;

  localparam int NSLOTS = 8;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic              HWRITE;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic [11:0]       PADDR;
  logic [NSLOTS-1:0] PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  always #5 HCLK = ~HCLK;

  // Single-slave bus: the bus-level ready is the bridge's own ready.
  assign HREADY = HREADYOUT;

  ahbl_apb_bridge #(
    .APB_AW   (12),
    .NSLOTS   (NSLOTS),
    .SLOT_LSB (12)
`ifdef APB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (4)
`endif
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  typedef struct {
    logic [31:0] hrdata;
    int          waits;
    logic        err;
    logic        sel;
    logic [7:0]  psel;
    logic [11:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cfg_wait;
  logic        cfg_err;
  logic [31:0] cfg_rdata;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one address phase now, push its expected outcome, and return just after the accepting edge.
  // tmo > 0 means the APB slave never answers and the bridge must give up after tmo ACCESS cycles.
  task automatic addr_phase(input logic [31:0] addr, input logic wr, input logic [1:0] htrans,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int nwait, input logic serr, input int tmo);
    exp_t       e;
    logic [3:0] slot;
    slot     = addr[15:12];
    e.sel    = (int'(slot) < NSLOTS);
    e.psel   = e.sel ? (8'd1 << slot) : 8'd0;
    e.paddr  = addr[11:0];
    e.pwrite = wr;
    e.pwdata = wdata;
    if (!e.sel) begin
      e.err   = 1'b1;
      e.waits = 2;
    end else if (tmo > 0) begin
      e.err   = 1'b1;
      e.waits = 3 + tmo;
    end else begin
      e.err   = serr;
      e.waits = 3 + nwait + (serr ? 1 : 0);
    end
    if (!e.err && !wr) model_rdata = rdata;
    e.hrdata = model_rdata;
    sb_q.push_back(e);
    cfg_wait  = nwait;
    cfg_err   = serr;
    cfg_rdata = rdata;
    HSEL   = 1'b1;
    HTRANS = htrans;
    HADDR  = addr;
    HWRITE = wr;
    @(posedge HCLK);
    #1;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = 32'hDEAD_BEEF;
    HWRITE = ~wr;
    HWDATA = wdata;
  endtask

  // Act as the APB slave through the data phase, then compare against the scoreboard head.
  task automatic data_phase(input string tag);
    exp_t e;
    int   waits = 0;
    int   acc   = 0;
    logic saw_sel   = 1'b0;
    logic last_resp = 1'b0;
    logic done      = 1'b0;
    e = sb_q.pop_front();
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge HCLK);
      if (HREADYOUT) begin
        done = 1'b1;
      end else begin
        waits++;
        last_resp = HRESP;
        if (PSEL != '0 && !PENABLE) begin
          saw_sel = 1'b1;
          check({tag, " setup psel"},   32'(PSEL),   32'(e.psel));
          check({tag, " setup paddr"},  32'(PADDR),  32'(e.paddr));
          check({tag, " setup pwrite"}, 32'(PWRITE), 32'(e.pwrite));
          if (e.pwrite) check({tag, " setup pwdata"}, PWDATA, e.pwdata);
        end
        if (PENABLE) begin
          check({tag, " access paddr"}, 32'(PADDR), 32'(e.paddr));
          check({tag, " access psel"},  32'(PSEL),  32'(e.psel));
          PREADY  = (acc == cfg_wait);
          PSLVERR = PREADY & cfg_err;
          PRDATA  = cfg_rdata;
          acc++;
        end else begin
          PREADY  = 1'b0;
          PSLVERR = 1'b0;
        end
      end
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    check({tag, " completed"},     32'(done),      32'd1);
    check({tag, " wait states"},   32'(waits),     32'(e.waits));
    check({tag, " err1 hresp"},    32'(last_resp), 32'(e.err));
    check({tag, " final hresp"},   32'(HRESP),     32'(e.err));
    check({tag, " psel issued"},   32'(saw_sel),   32'(e.sel));
    check({tag, " hrdata"},        HRDATA,         e.hrdata);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " hreadyout"}, 32'(HREADYOUT), 32'd1);
    check({tag, " hresp"},     32'(HRESP),     32'd0);
    check({tag, " psel"},      32'(PSEL),      32'd0);
    check({tag, " penable"},   32'(PENABLE),   32'd0);
  endtask

  initial begin
    HRESET = 1'b1;
    HSEL   = 1'b0;
    HADDR  = '0;
    HWRITE = 1'b0;
    HTRANS = 2'b00;
    HSIZE  = 3'b010;
    HWDATA = '0;
    PRDATA = '0;
    PREADY = 1'b0;
    PSLVERR = 1'b0;

    #1;
    check_quiet("reset");
    check("reset hrdata", HRDATA,          32'h0);
    check("reset paddr",  32'(PADDR),      32'h0);
    check("reset pwrite", 32'(PWRITE),     32'h0);
    check("reset pwdata", PWDATA,          32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Selected but IDLE transfer, then NONSEQ with HSEL low: neither may start anything.
    HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h0000_3004;
    @(negedge HCLK); @(negedge HCLK);
    check_quiet("idle htrans");
    HSEL = 1'b0; HTRANS = 2'b10;
    @(negedge HCLK); @(negedge HCLK);
    check_quiet("hsel low");
    HTRANS = 2'b00;
    @(negedge HCLK);

    addr_phase(32'h0000_3004, 1'b1, 2'b10, 32'hA5A5_0001, 32'h0, 0, 1'b0, 0);
    data_phase("write slot3");
    @(negedge HCLK);

    addr_phase(32'h0000_1010, 1'b0, 2'b10, 32'h0, 32'h1234_5678, 2, 1'b0, 0);
    data_phase("read wait2");
    @(negedge HCLK);

    // Slave error, then decode error accepted straight out of ERR2, then a write out of ERR2 again.
    addr_phase(32'h0000_2000, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFF, 0, 1'b1, 0);
    data_phase("read slverr");
    addr_phase(32'h0000_9000, 1'b0, 2'b10, 32'h0, 32'h5555_5555, 0, 1'b0, 0);
    data_phase("decode err");
    addr_phase(32'h0000_4ABC, 1'b1, 2'b10, 32'h0F0F_0F0F, 32'h0, 1, 1'b0, 0);
    data_phase("write after err2");

    // Back-to-back: the next address phase sits in the completion cycle of the previous transfer.
    addr_phase(32'h0000_5010, 1'b1, 2'b10, 32'hC0DE_0001, 32'h0, 0, 1'b0, 0);
    data_phase("b2b write");
    addr_phase(32'h0000_6020, 1'b0, 2'b11, 32'h0, 32'h8765_4321, 0, 1'b0, 0);
    data_phase("b2b read");

    // Reset pulsed while ACCESS is stalled: outputs must clear before the next edge.
    addr_phase(32'h0000_2008, 1'b0, 2'b10, 32'h0, 32'hCAFE_0000, 1000, 1'b0, 0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 10 && !PENABLE; i++) @(negedge HCLK);
    check("rst reached access", 32'(PENABLE), 32'd1);
    HRESET = 1'b1;
    #1;
    check_quiet("mid-access reset");
    check("mid-access reset hrdata", HRDATA, 32'h0);
    model_rdata = 32'h0;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);

    addr_phase(32'h0000_7FFC, 1'b0, 2'b10, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 0);
    data_phase("read after reset");

`ifdef APB_TIMEOUT_EN
    @(negedge HCLK);
    addr_phase(32'h0000_1100, 1'b0, 2'b10, 32'h0, 32'h7777_7777, 1000, 1'b0, 4);
    data_phase("timeout");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
